// File: rtl/z80_bus_initiator_if.sv
// Command/response handshake and Z80 bus pins of the bus initiator.
// The master modport is the initiator's view, and the slave modport is the view from the command side and the target.
interface z80_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_io;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        wait_n;

  modport master (
    input  cmd_valid, cmd_io, cmd_wr, cmd_addr, cmd_wdata, d_in, wait_n,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, a, d_out, d_oe,
    output mreq_n, iorq_n, rd_n, wr_n
  );

  modport slave (
    output cmd_valid, cmd_io, cmd_wr, cmd_addr, cmd_wdata, d_in, wait_n,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, a, d_out, d_oe,
    input  mreq_n, iorq_n, rd_n, wr_n
  );
endinterface

// File: rtl/z80_bus_initiator.sv
// Z80-style bus initiator: turns one command into a T1/T2/(TWA)/(TW*)/T3 memory or I/O cycle.
// Each T-state is TDIV clk long; wait_n stretches the cycle, and WAIT_MAX bounds the stretch.
module z80_bus_initiator #(
  parameter int TDIV     = 1,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  z80_bus_initiator_if.master  bus
);
  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, T1, T2, TWA, TW, T3} state_t;

  state_t         state_q, state_d;
  logic [5:0]     tcnt_q, tcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           io_q, io_d;
  logic           wr_q, wr_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_err_q, rsp_err_d;
  logic           last;
  logic           timeout;
  logic           active;

  assign last    = (tcnt_q == 6'(TDIV - 1));
  assign timeout = (WAIT_MAX != 0) && ((int'(wcnt_q) + 1) >= WAIT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      wcnt_q      <= '0;
      io_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      wcnt_q      <= wcnt_d;
      io_q        <= io_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    wcnt_d      = wcnt_q;
    io_d        = io_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;

    if (state_q != IDLE) begin
      tcnt_d = last ? 6'd0 : tcnt_q + 6'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          io_d    = bus.cmd_io;
          wr_d    = bus.cmd_wr;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          tcnt_d  = 6'd0;
          wcnt_d  = '0;
          state_d = T1;
        end
      end
      T1: if (last) state_d = T2;
      // I/O cycles insert the automatic wait state before wait_n is looked at.
      T2: begin
        if (last) begin
          if (io_q) state_d = TWA;
          else      state_d = bus.wait_n ? T3 : TW;
        end
      end
      TWA: if (last) state_d = bus.wait_n ? T3 : TW;
      TW: begin
        if (last) begin
          if (bus.wait_n) begin
            state_d = T3;
          end else begin
            if (wcnt_q != {WCW{1'b1}}) wcnt_d = wcnt_q + WCW'(1);
            if (timeout) begin
              state_d     = IDLE;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rdata_d     = 8'h00;
            end
          end
        end
      end
      T3: begin
        if (last) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!wr_q) rdata_d = bus.d_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active = (state_q == T2) || (state_q == TWA) || (state_q == TW) || (state_q == T3);

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.a         = addr_q;
  assign bus.d_out     = wdata_q;
  assign bus.d_oe      = wr_q && (state_q != IDLE);
  assign bus.mreq_n    = !(active && !io_q);
  assign bus.iorq_n    = !(active && io_q);
  assign bus.rd_n      = !(active && !wr_q);
  assign bus.wr_n      = !(active && wr_q);
endmodule

// File: tb/tb_z80_bus_initiator.sv
// Directed bench for z80_bus_initiator: one TDIV=1/WAIT_MAX=4 instance and one TDIV=3 instance,
// both driven from shared command signals; sel picks which one gets cmd_valid and is observed.
module tb_z80_bus_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_io = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  d_in = '0;
  logic        wait_n = 1'b1;

  int n_assert = 0;
  int n_fail = 0;

  z80_bus_initiator_if bus1();
  z80_bus_initiator_if bus3();

  assign bus1.cmd_valid = cmd_valid & ~sel;
  assign bus1.cmd_io    = cmd_io;
  assign bus1.cmd_wr    = cmd_wr;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus1.cmd_wdata = cmd_wdata;
  assign bus1.d_in      = d_in;
  assign bus1.wait_n    = wait_n;
  assign bus3.cmd_valid = cmd_valid & sel;
  assign bus3.cmd_io    = cmd_io;
  assign bus3.cmd_wr    = cmd_wr;
  assign bus3.cmd_addr  = cmd_addr;
  assign bus3.cmd_wdata = cmd_wdata;
  assign bus3.d_in      = d_in;
  assign bus3.wait_n    = wait_n;

  z80_bus_initiator #(.TDIV(1), .WAIT_MAX(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  z80_bus_initiator #(.TDIV(3), .WAIT_MAX(255)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  logic        o_ready, o_rsp_valid, o_err, o_d_oe;
  logic        o_mreq_n, o_iorq_n, o_rd_n, o_wr_n;
  logic [7:0]  o_rdata, o_d_out;
  logic [15:0] o_a;

  always_comb begin
    o_ready     = sel ? bus3.cmd_ready : bus1.cmd_ready;
    o_rsp_valid = sel ? bus3.rsp_valid : bus1.rsp_valid;
    o_err       = sel ? bus3.rsp_err   : bus1.rsp_err;
    o_rdata     = sel ? bus3.rsp_rdata : bus1.rsp_rdata;
    o_d_oe      = sel ? bus3.d_oe      : bus1.d_oe;
    o_d_out     = sel ? bus3.d_out     : bus1.d_out;
    o_a         = sel ? bus3.a         : bus1.a;
    o_mreq_n    = sel ? bus3.mreq_n    : bus1.mreq_n;
    o_iorq_n    = sel ? bus3.iorq_n    : bus1.iorq_n;
    o_rd_n      = sel ? bus3.rd_n      : bus1.rd_n;
    o_wr_n      = sel ? bus3.wr_n      : bus1.wr_n;
  end

  int         m_strb, m_rw, m_oe, m_rsp, m_addr_bad, m_dout_bad, m_other_bad;
  logic [7:0] m_rdata;
  logic       m_err, m_ready_c1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call in the acceptance cycle (cycle 0); counts bus activity per cycle until rsp_valid or the budget runs out.
  task automatic run_txn(input int max_cycles, input int wait_release, input bit hold, input bit scribble);
    logic        exp_io, exp_wr;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    exp_io = cmd_io; exp_wr = cmd_wr; exp_addr = cmd_addr; exp_wdata = cmd_wdata;
    m_strb = 0; m_rw = 0; m_oe = 0; m_rsp = -1;
    m_addr_bad = 0; m_dout_bad = 0; m_other_bad = 0;
    m_rdata = 8'hxx; m_err = 1'bx; m_ready_c1 = 1'bx;
    for (int c = 1; c <= max_cycles; c++) begin
      tick();
      if (!hold) cmd_valid = 1'b0;
      if (scribble && c == 2) begin
        cmd_addr = ~exp_addr; cmd_wdata = ~exp_wdata; cmd_io = ~exp_io; cmd_wr = ~exp_wr;
      end
      wait_n = (c >= wait_release);
      if (c == 1) m_ready_c1 = o_ready;
      if ((exp_io ? o_iorq_n : o_mreq_n) == 1'b0) m_strb++;
      if ((exp_io ? o_mreq_n : o_iorq_n) == 1'b0) m_other_bad++;
      if ((exp_wr ? o_wr_n : o_rd_n) == 1'b0) m_rw++;
      if ((exp_wr ? o_rd_n : o_wr_n) == 1'b0) m_other_bad++;
      if (o_d_oe) begin
        m_oe++;
        if (o_d_out !== exp_wdata) m_dout_bad++;
      end
      if (!o_ready && o_a !== exp_addr) m_addr_bad++;
      if (o_rsp_valid) begin
        m_rsp = c; m_rdata = o_rdata; m_err = o_err;
        break;
      end
    end
  endtask

  task automatic start_cmd(input logic io, input logic wr, input logic [15:0] addr, input logic [7:0] wdata);
    cmd_io = io; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rsp_seen;
    #2 reset = 1'b0;
    #1;
    check_output("reset_strobes", {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}, 4'hF);
    check_output("reset_d_oe", o_d_oe, 1'b0);
    check_output("reset_a", o_a, 16'h0000);
    check_output("reset_d_out", o_d_out, 8'h00);
    check_output("reset_rsp", {o_rsp_valid, o_err}, 2'b00);
    check_output("reset_rdata", o_rdata, 8'h00);
    check_output("reset_a_tdiv3", bus3.a, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    check_output("ready_after_release", o_ready, 1'b1);

    $display("[TB] memory read 0x2000, TDIV=1");
    d_in = 8'h5A;
    start_cmd(1'b0, 1'b0, 16'h2000, 8'h00);
    run_txn(12, 0, 1'b0, 1'b0);
    check_output("mrd_ready_t1", m_ready_c1, 1'b0);
    check_output("mrd_mreq_low", m_strb, 2);
    check_output("mrd_rd_low", m_rw, 2);
    check_output("mrd_d_oe", m_oe, 0);
    check_output("mrd_rsp_cycle", m_rsp, 4);
    check_output("mrd_rdata", m_rdata, 8'h5A);
    check_output("mrd_err", m_err, 1'b0);
    check_output("mrd_addr", m_addr_bad, 0);
    check_output("mrd_other", m_other_bad, 0);
    tick();
    check_output("mrd_pulse_end", o_rsp_valid, 1'b0);
    check_output("mrd_a_hold", o_a, 16'h2000);

    $display("[TB] I/O write 0x00D8 <- 0x03, TDIV=1");
    d_in = 8'hEE;
    start_cmd(1'b1, 1'b1, 16'h00D8, 8'h03);
    run_txn(12, 0, 1'b0, 1'b0);
    check_output("iowr_iorq_low", m_strb, 3);
    check_output("iowr_wr_low", m_rw, 3);
    check_output("iowr_d_oe", m_oe, 4);
    check_output("iowr_d_out", m_dout_bad, 0);
    check_output("iowr_addr", m_addr_bad, 0);
    check_output("iowr_other", m_other_bad, 0);
    check_output("iowr_rsp_cycle", m_rsp, 5);
    check_output("iowr_err", m_err, 1'b0);
    check_output("iowr_rdata_kept", m_rdata, 8'h5A);
    tick();

    $display("[TB] memory read 0x1234 with three wait samples");
    d_in = 8'hC3;
    start_cmd(1'b0, 1'b0, 16'h1234, 8'h00);
    run_txn(20, 5, 1'b0, 1'b0);
    check_output("wait_mreq_low", m_strb, 5);
    check_output("wait_rd_low", m_rw, 5);
    check_output("wait_rsp_cycle", m_rsp, 7);
    check_output("wait_rdata", m_rdata, 8'hC3);
    check_output("wait_err", m_err, 1'b0);
    tick();

    $display("[TB] memory read with wait_n stuck low, WAIT_MAX=4");
    d_in = 8'h99;
    start_cmd(1'b0, 1'b0, 16'h4321, 8'h00);
    run_txn(30, 1000, 1'b0, 1'b0);
    wait_n = 1'b1;
    check_output("tmo_mreq_low", m_strb, 5);
    check_output("tmo_rsp_cycle", m_rsp, 7);
    check_output("tmo_err", m_err, 1'b1);
    check_output("tmo_rdata", m_rdata, 8'h00);
    tick();
    check_output("tmo_strobes_idle", {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}, 4'hF);

    $display("[TB] TDIV=3 memory write with cmd_valid held, then back-to-back read");
    sel = 1'b1;
    tick();
    start_cmd(1'b0, 1'b1, 16'hBEEF, 8'hA5);
    run_txn(40, 0, 1'b1, 1'b1);
    check_output("t3wr_mreq_low", m_strb, 6);
    check_output("t3wr_wr_low", m_rw, 6);
    check_output("t3wr_d_oe", m_oe, 9);
    check_output("t3wr_d_out", m_dout_bad, 0);
    check_output("t3wr_addr_ignored", m_addr_bad, 0);
    check_output("t3wr_other", m_other_bad, 0);
    check_output("t3wr_rsp_cycle", m_rsp, 10);
    check_output("t3wr_err", m_err, 1'b0);
    d_in = 8'h77;
    start_cmd(1'b0, 1'b0, 16'h0102, 8'h00);
    run_txn(40, 0, 1'b0, 1'b0);
    check_output("b2b_ready_t1", m_ready_c1, 1'b0);
    check_output("b2b_rsp_cycle", m_rsp, 10);
    check_output("b2b_mreq_low", m_strb, 6);
    check_output("b2b_d_oe", m_oe, 0);
    check_output("b2b_addr", m_addr_bad, 0);
    check_output("b2b_rdata", m_rdata, 8'h77);
    tick();
    check_output("b2b_pulse_end", o_rsp_valid, 1'b0);

    $display("[TB] reset during T2 of an I/O read");
    sel = 1'b0;
    tick();
    start_cmd(1'b1, 1'b0, 16'h0040, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tick();
    check_output("rst_pre_strobes", {o_iorq_n, o_rd_n}, 2'b00);
    #1 reset = 1'b0;
    #1;
    check_output("rst_strobes", {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}, 4'hF);
    check_output("rst_d_oe", o_d_oe, 1'b0);
    check_output("rst_rsp_valid", o_rsp_valid, 1'b0);
    tick(); tick();
    reset = 1'b1;
    check_output("rst_ready", o_ready, 1'b1);
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_rsp_valid) rsp_seen++;
    end
    check_output("rst_no_rsp", rsp_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/z80_bus_initiator.md
Z80_BUS_INITIATOR -- requirements
Module: z80_bus_initiator

Interface
REQ-001 SHALL have parameter TDIV, default 1: clk cycles per T-state, legal range 1..64.
REQ-002 SHALL have parameter WAIT_MAX, default 255: maximum consecutive TW states before abort; 0 disables the timeout.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_io  in  1  1 = I/O cycle (iorq_n), 0 = memory cycle (mreq_n).
REQ-008 cmd_wr  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  16  bus address.
REQ-010 cmd_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  one-clk pulse at cycle completion.
REQ-012 rsp_rdata  out  8  read data, qualified by rsp_valid.
REQ-013 rsp_err  out  1  wait timeout flag, qualified by rsp_valid.
REQ-014 a  out  16  address bus.
REQ-015 d_out / d_oe / d_in  out/out/in  8/1/8  data bus output, output enable, and input.
REQ-016 mreq_n, iorq_n, rd_n, wr_n  out  1 each  active-low bus strobes.
REQ-017 wait_n  in  1  active-low wait from target.

Function
REQ-018 SHALL implement states IDLE, T1, T2, TWA, TW, T3; cmd_ready=1 only in IDLE.
REQ-019 On acceptance, SHALL latch io, wr, addr, and wdata, clear the T-state counter, and enter T1 next clk.
REQ-020 Each non-IDLE state SHALL last exactly TDIV clk; the transition occurs on the clk where the counter equals TDIV-1.
REQ-021 Transitions: T1->T2; T2->TWA if io; T2/TWA->TW if wait_n=0 else T3; TW->TW while wait_n=0 else T3; T3->IDLE.
REQ-022 wait_n SHALL be sampled only on the last clk of T2, TWA or TW.
REQ-023 a SHALL equal the latched address in T1..T3; it SHALL hold its last value in IDLE.
REQ-024 Selected strobe (mreq_n or iorq_n) and rd_n/wr_n SHALL be low in T2, TWA, TW, T3 and high in IDLE/T1; the other strobes SHALL be high.
REQ-025 For writes, d_oe=1 and d_out=wdata SHALL hold in T1..T3; d_oe SHALL be 0 for reads and in IDLE.
REQ-026 Read data: d_in SHALL be captured on the last clk of T3 into rsp_rdata.
REQ-027 rsp_valid SHALL pulse for exactly one clk on the first IDLE clk after T3; rsp_err=0 on that pulse.
REQ-028 rsp_rdata SHALL be unchanged for writes and hold its value between responses.
REQ-029 Timeout (WAIT_MAX>0): when WAIT_MAX TW states have elapsed with wait_n still 0, the block SHALL go to IDLE with strobes high, pulse rsp_valid with rsp_err=1, and set rsp_rdata=0.
REQ-030 The TW counter SHALL saturate and never wrap, and SHALL clear on each acceptance.
REQ-031 cmd_valid in the rsp_valid clk SHALL be accepted; back-to-back cycles are separated by exactly one IDLE clk.
REQ-032 Command inputs SHALL be ignored outside IDLE.
REQ-033 Latency with TDIV=1 and no waits: memory cycle rsp_valid 4 clk after acceptance; I/O cycle 5 clk after acceptance.

Reset
REQ-034 reset=0 SHALL immediately force: state IDLE; mreq_n=iorq_n=rd_n=wr_n=1; d_oe=0; a=0; d_out=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; counters=0.
REQ-035 Reset mid-cycle SHALL abort the cycle without issuing rsp_valid.
REQ-036 After reset release, cmd_ready SHALL be 1 on the first clk.

Verification
REQ-037 I/O write, TDIV=1, addr 0x00D8, wdata 0x03, wait_n=1 -> a=0x00D8, d_oe high for 4 clk, iorq_n/wr_n low for 3 clk, rsp_valid at +5, rsp_err=0.
REQ-038 Memory read 0x2000, d_in=0x5A, TDIV=1 -> mreq_n/rd_n low for 2 clk, rsp_rdata=0x5A at +4, d_oe=0 throughout.
REQ-039 Memory read with wait_n=0 for the first 3 samples -> 3 TW states, strobes low for 5 clk, rsp_valid at +7.
REQ-040 WAIT_MAX=4, wait_n stuck 0 -> strobes release after 4 TW, rsp_valid with rsp_err=1 and rsp_rdata=0x00.
REQ-041 TDIV=3 memory write -> each state 3 clk, strobes low for 6 clk, rsp_valid at +10; cmd_valid held -> second cycle T1 starts 1 clk after rsp_valid.
REQ-042 reset asserted during T2 of an I/O read -> all strobes high and d_oe=0 in the same cycle, no rsp_valid, cmd_ready=1 after release.
